// File: rtl/stream_frame_reader.sv
// Stream frame reader: hunts a byte stream for a 32-bit sync word, then packs
// FrameLength payload words (MSB-first) onto a valid/ready word interface.
// Upstream is a pop-style converter whose byte appears one cycle after ReadEnable.
module stream_frame_reader #(
    parameter logic [31:0] SYNC_WORD      = 32'hFF807F00,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  DataIn,
    input  logic        DataValid,
    input  logic        DataReadyToSend,
    output logic        ReadEnable,
    input  logic        Arm,
    input  logic [11:0] FrameLength,
    output logic [31:0] WordOut,
    output logic        WordValid,
    input  logic        WordReady,
    output logic [11:0] WordCount,
    output logic        FrameDone,
    output logic        SyncError,
    output logic [3:0]  State
);

    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [3:0] {
        S_IDLE    = 4'b0001,
        S_HUNT    = 4'b0010,
        S_PAYLOAD = 4'b0100,
        S_DONE    = 4'b1000
    } state_e;

    state_e        state_q;
    // Only the three older window bytes are stored; the newest byte is DataIn itself.
    logic [23:0]   window_q;
    // First three bytes of the word being assembled; the fourth goes straight out.
    logic [23:0]   asm_q;
    logic [1:0]    bcnt_q;
    logic [13:0]   acc_q;      // payload bytes accepted this frame
    logic          re_q;       // a byte requested last cycle is arriving now
    logic [GW-1:0] gap_q;
    logic [11:0]   len_q;
    logic [11:0]   wcount_q;
    logic [31:0]   word_q;
    logic          wvalid_q;
    logic          done_q;
    logic          serr_q;

    logic [31:0]   window_d;
    logic [31:0]   word_d;
    logic          more_bytes;

    assign window_d = {window_q, DataIn};
    assign word_d   = {asm_q, DataIn};

    // Stop requesting once accepted + in-flight bytes cover the whole frame, so
    // nothing past the last payload byte is popped from upstream.
    assign more_bytes = ({1'b0, acc_q} + {14'd0, re_q}) < {1'b0, len_q, 2'b00};

    assign ReadEnable = DataReadyToSend
                      & ((state_q == S_HUNT) | ((state_q == S_PAYLOAD) & more_bytes))
                      & ~(wvalid_q & ~WordReady);

    assign WordOut   = word_q;
    assign WordValid = wvalid_q;
    assign WordCount = wcount_q;
    assign FrameDone = done_q;
    assign SyncError = serr_q;
    assign State     = state_q;

    // Frame FSM with the window, assembly, counters and registered outputs.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q  <= S_IDLE;
            window_q <= '0;
            asm_q    <= '0;
            bcnt_q   <= '0;
            acc_q    <= '0;
            re_q     <= 1'b0;
            gap_q    <= '0;
            len_q    <= '0;
            wcount_q <= '0;
            word_q   <= '0;
            wvalid_q <= 1'b0;
            done_q   <= 1'b0;
            serr_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            serr_q <= 1'b0;
            re_q   <= ReadEnable;
            // Handshake retires the word; a load below in the same cycle wins.
            if (wvalid_q && WordReady) wvalid_q <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (Arm) begin
                        state_q  <= S_HUNT;
                        window_q <= '0;
                        wcount_q <= '0;
                    end
                end
                S_HUNT: begin
                    if (DataValid) begin
                        window_q <= window_d[23:0];
                        if (window_d == SYNC_WORD) begin
                            len_q   <= FrameLength;
                            acc_q   <= '0;
                            bcnt_q  <= '0;
                            gap_q   <= '0;
                            state_q <= (FrameLength == 12'd0) ? S_DONE : S_PAYLOAD;
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (DataValid) begin
                        gap_q  <= '0;
                        acc_q  <= acc_q + 14'd1;
                        bcnt_q <= bcnt_q + 2'd1;
                        asm_q  <= {asm_q[15:0], DataIn};
                        if (bcnt_q == 2'd3) begin
                            word_q   <= word_d;
                            wvalid_q <= 1'b1;
                            wcount_q <= wcount_q + 12'd1;
                            if (wcount_q + 12'd1 == len_q) state_q <= S_DONE;
                        end
                    end else if (gap_q == GW'(TIMEOUT_CYCLES - 1)) begin
                        // Timeout drops the partial word; a loaded word stays presented.
                        serr_q  <= 1'b1;
                        bcnt_q  <= '0;
                        asm_q   <= '0;
                        gap_q   <= '0;
                        state_q <= S_IDLE;
                    end else begin
                        gap_q <= gap_q + GW'(1);
                    end
                end
                S_DONE: begin
                    if (!wvalid_q || WordReady) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stream_frame_reader.sv
// Directed bench for stream_frame_reader: an upstream byte queue model that
// answers ReadEnable one cycle later, and a word scoreboard checked on handshake.
module tb_stream_frame_reader;

    logic        Clock;
    logic        Reset;
    logic [7:0]  DataIn;
    logic        DataValid;
    logic        DataReadyToSend;
    logic        ReadEnable;
    logic        Arm;
    logic [11:0] FrameLength;
    logic [31:0] WordOut;
    logic        WordValid;
    logic        WordReady;
    logic [11:0] WordCount;
    logic        FrameDone;
    logic        SyncError;
    logic [3:0]  State;

    stream_frame_reader #(.SYNC_WORD(32'hFF807F00), .TIMEOUT_CYCLES(16)) dut (
        .Clock(Clock), .Reset(Reset), .DataIn(DataIn), .DataValid(DataValid),
        .DataReadyToSend(DataReadyToSend), .ReadEnable(ReadEnable), .Arm(Arm),
        .FrameLength(FrameLength), .WordOut(WordOut), .WordValid(WordValid),
        .WordReady(WordReady), .WordCount(WordCount), .FrameDone(FrameDone),
        .SyncError(SyncError), .State(State)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int          checks = 0;
    int          errors = 0;
    logic [7:0]  src[$];
    logic [31:0] exp_q[$];
    bit          src_en;
    bit          pop;
    bit          hold_v;
    logic [31:0] hold_w;
    int          fd_cnt, se_cnt, wv_cnt, dv_cnt, pop_cnt;
    int          n, done_t, fd_t;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] b);
        src.push_back(b);
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) src.push_back(w[i*8 +: 8]);
    endtask

    task automatic clear_counts();
        fd_cnt = 0; se_cnt = 0; wv_cnt = 0; dv_cnt = 0; pop_cnt = 0;
    endtask

    // One clock: settle inputs, check word handshake/hold, cross the edge,
    // present the popped byte, then tally pulses.
    task automatic tick();
        logic [31:0] w;
        DataReadyToSend = src_en && (src.size() != 0);
        #1;
        if (WordValid && WordReady) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word observed=%h expected=none", WordOut);
            end
            if (exp_q.size() != 0) begin
                w = exp_q.pop_front();
                check("word_out", WordOut, w);
            end
        end
        if (WordValid && !WordReady) begin
            if (hold_v) check("held_word_stable", WordOut, hold_w);
            hold_v = 1'b1;
            hold_w = WordOut;
        end else begin
            hold_v = 1'b0;
        end
        pop = ReadEnable;
        if (pop) pop_cnt++;
        @(negedge Clock);
        if (pop && src.size() != 0) begin
            DataIn    = src.pop_front();
            DataValid = 1'b1;
            dv_cnt++;
        end else begin
            DataValid = 1'b0;
        end
        #1;
        if (FrameDone) fd_cnt++;
        if (SyncError) se_cnt++;
        if (WordValid) wv_cnt++;
    endtask

    task automatic arm_frame(input logic [11:0] len);
        FrameLength = len;
        Arm = 1'b1;
        tick();
        Arm = 1'b0;
        check("arm_enters_hunt", {28'd0, State}, 32'h2);
        check("arm_clears_count", {20'd0, WordCount}, 32'd0);
        src_en = 1'b1;
    endtask

    task automatic wait_frame_done();
        for (int i = 0; i < 300 && fd_cnt == 0; i++) tick();
        repeat (3) tick();
        check("frame_done_pulses", fd_cnt, 1);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1; Arm = 1'b0; FrameLength = '0; WordReady = 1'b1;
        DataIn = '0; DataValid = 1'b0; DataReadyToSend = 1'b0; src_en = 1'b0;
        hold_v = 1'b0; hold_w = '0;
        clear_counts();
        repeat (3) tick();
        Reset = 1'b0;
        tick();

        // Reset state, with upstream claiming data
        push_byte(8'h5A);
        src_en = 1'b1;
        DataReadyToSend = 1'b1;
        #1;
        check("rst_state", {28'd0, State}, 32'h1);
        check("rst_read_enable", {31'd0, ReadEnable}, 32'd0);
        check("rst_word_out", WordOut, 32'd0);
        check("rst_outputs", {16'd0, WordValid, FrameDone, SyncError, 1'b0, WordCount}, 32'd0);
        tick(); tick();
        check("idle_no_pop", src.size(), 1);
        src_en = 1'b0; src.delete();

        // Aligned two-word frame; trailing byte must stay upstream
        clear_counts();
        push_word(32'hFF807F00); push_word(32'h11223344); push_word(32'h55667788);
        push_byte(8'h99);
        exp_q.push_back(32'h11223344); exp_q.push_back(32'h55667788);
        arm_frame(12'd2);
        wait_frame_done();
        check("f1_word_count", {20'd0, WordCount}, 32'd2);
        check("f1_words_seen", wv_cnt, 2);
        check("f1_scoreboard_empty", exp_q.size(), 0);
        check("f1_no_overread", src.size(), 1);
        check("f1_idle", {28'd0, State}, 32'h1);
        check("f1_no_sync_error", se_cnt, 0);
        src_en = 1'b0; src.delete();

        // Header at an unaligned offset
        clear_counts();
        push_byte(8'h00); push_byte(8'hFF); push_byte(8'hFF); push_byte(8'h80);
        push_byte(8'h7F); push_byte(8'h00);
        push_word(32'hAABBCCDD);
        exp_q.push_back(32'hAABBCCDD);
        arm_frame(12'd1);
        wait_frame_done();
        check("f2_word_count", {20'd0, WordCount}, 32'd1);
        check("f2_scoreboard_empty", exp_q.size(), 0);
        src_en = 1'b0; src.delete();

        // Downstream stall after the first word
        clear_counts();
        push_word(32'hFF807F00); push_word(32'h01020304); push_word(32'hA5B6C7D8);
        exp_q.push_back(32'h01020304); exp_q.push_back(32'hA5B6C7D8);
        WordReady = 1'b0;
        arm_frame(12'd2);
        for (int i = 0; i < 100 && !WordValid; i++) tick();
        check("stall_word_valid", {31'd0, WordValid}, 32'd1);
        check("stall_re_low", {31'd0, ReadEnable}, 32'd0);
        dv_cnt = 0; pop_cnt = 0;
        repeat (10) tick();
        check("stall_no_pops", pop_cnt, 0);
        check("stall_extra_bytes_le1", {31'd0, dv_cnt <= 1}, 32'd1);
        check("stall_first_word_held", WordOut, 32'h01020304);
        WordReady = 1'b1;
        wait_frame_done();
        check("stall_word_count", {20'd0, WordCount}, 32'd2);
        check("stall_scoreboard_empty", exp_q.size(), 0);
        src_en = 1'b0; src.delete();

        // Payload timeout after two bytes
        clear_counts();
        push_word(32'hFF807F00); push_byte(8'h12); push_byte(8'h34);
        arm_frame(12'd1);
        for (int i = 0; i < 60 && !(src.size() == 0 && DataValid); i++) tick();
        n = 0;
        while (se_cnt == 0 && n < 40) begin tick(); n++; end
        check("timeout_edges", 32'(n - 1), 32'd16);
        check("timeout_idle", {28'd0, State}, 32'h1);
        repeat (3) tick();
        check("timeout_one_pulse", se_cnt, 1);
        check("timeout_no_word", wv_cnt, 0);
        check("timeout_no_done", fd_cnt, 0);
        src_en = 1'b0; src.delete();

        // Zero-length frame
        clear_counts();
        push_word(32'hFF807F00);
        arm_frame(12'd0);
        done_t = -1; fd_t = -1; n = 0;
        while (fd_cnt == 0 && n < 50) begin
            tick(); n++;
            if (State == 4'b1000) done_t = n;
            if (fd_cnt != 0) fd_t = n;
        end
        check("len0_done_seen", {31'd0, done_t > 0}, 32'd1);
        check("len0_done_latency", 32'(fd_t - done_t), 32'd1);
        check("len0_no_word", wv_cnt, 0);
        src_en = 1'b0; src.delete();

        // Reset mid-payload with a word held at the output
        clear_counts();
        push_word(32'hFF807F00); push_word(32'hCAFEF00D); push_word(32'h12345678);
        WordReady = 1'b0;
        arm_frame(12'd2);
        for (int i = 0; i < 100 && !WordValid; i++) tick();
        check("mid_word_loaded", WordOut, 32'hCAFEF00D);
        Reset = 1'b1;
        #1;
        check("mid_rst_state", {28'd0, State}, 32'h1);
        check("mid_rst_word_out", WordOut, 32'd0);
        check("mid_rst_outputs", {16'd0, WordValid, FrameDone, SyncError, ReadEnable, WordCount}, 32'd0);
        clear_counts();
        repeat (3) tick();
        Reset = 1'b0;
        WordReady = 1'b1;
        repeat (5) tick();
        check("mid_rst_stays_idle", {28'd0, State}, 32'h1);
        check("mid_rst_no_pulses", fd_cnt + se_cnt + wv_cnt, 0);
        src_en = 1'b0; src.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/stream_frame_reader.md
STREAM_FRAME_READER -- requirements
Module: stream_frame_reader

Interface
REQ-001 SHALL have parameter SYNC_WORD, default 32'hFF807F00: frame signature.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum gap between payload bytes.
REQ-003 SHALL have port Clock  input  1: the single clock; all logic is rising-edge.
REQ-004 SHALL have port Reset  input  1: reset, asynchronous, active-high.
REQ-005 SHALL have port DataIn  input  8: byte from the storage converter; valid one cycle after ReadEnable.
REQ-006 SHALL have port DataValid  input  1: DataIn holds a byte this cycle.
REQ-007 SHALL have port DataReadyToSend  input  1: the upstream converter is non-empty.
REQ-008 SHALL have port ReadEnable  output  1: pop one byte from the upstream converter.
REQ-009 SHALL have port Arm  input  1: start a hunt for the next frame.
REQ-010 SHALL have port FrameLength  input  12: number of 32-bit payload words per frame.
REQ-011 SHALL have port WordOut  output  32: assembled payload word, first byte received in [31:24].
REQ-012 SHALL have port WordValid  output  1: WordOut is valid.
REQ-013 SHALL have port WordReady  input  1: the downstream consumer accepts WordOut.
REQ-014 SHALL have port WordCount  output  12: words delivered in the current frame.
REQ-015 SHALL have port FrameDone  output  1: one-cycle pulse at frame end.
REQ-016 SHALL have port SyncError  output  1: one-cycle pulse on timeout.
REQ-017 SHALL have port State  output  4: one-hot state, IDLE=0001, HUNT=0010, PAYLOAD=0100, DONE=1000.

Function
REQ-018 IDLE SHALL go to HUNT on a cycle with Arm=1; entering HUNT SHALL clear the 32-bit sliding window and WordCount.
REQ-019 ReadEnable SHALL equal DataReadyToSend & (HUNT or PAYLOAD) & ~(WordValid & ~WordReady).
REQ-020 Every byte with DataValid=1 in HUNT or PAYLOAD SHALL be accepted.
  - Accepted bytes are never dropped, including one in-flight byte arriving after ReadEnable falls.
REQ-021 HUNT: each accepted byte SHALL shift into the window LSB side: window <= {window[23:0], DataIn}.
REQ-022 HUNT: when the updated window equals SYNC_WORD, the block SHALL latch FrameLength and go to PAYLOAD next cycle.
  - The match works at any byte alignment.
  - If the latched FrameLength is 0, the block SHALL go to DONE instead.
REQ-023 PAYLOAD: accepted bytes SHALL fill a separate 4-byte assembly register MSB first, using a 2-bit byte counter.
REQ-024 On the 4th byte, the assembled word SHALL load the output register the next cycle.
  - WordValid is set; WordCount increments.
  - A word held for more than 4 bytes is impossible by REQ-019.
REQ-025 WordValid SHALL stay high with WordOut stable until a cycle with WordReady=1; it SHALL drop the following cycle unless a new word loads.
REQ-026 When WordCount reaches the latched length, the block SHALL go to DONE.
  - It stops reading; no bytes are consumed beyond the frame.
REQ-027 DONE SHALL assert FrameDone for exactly one cycle once the last word has been accepted, then go to IDLE.
REQ-028 PAYLOAD timeout:
  - A gap counter counts cycles with no accepted byte.
  - At TIMEOUT_CYCLES the block SHALL pulse SyncError, discard any partial word, and go to IDLE.
  - A word already in the output register SHALL still be presented.
REQ-029 Arm changes outside IDLE SHALL be ignored.
REQ-030 A DataValid byte in IDLE or DONE SHALL be ignored.

Reset
REQ-031 Reset=1 SHALL asynchronously force:
  - State=0001; ReadEnable, WordValid, FrameDone, SyncError = 0.
  - WordOut=0; WordCount=0; window, assembly register and counters cleared.
REQ-032 Reset asserted mid-frame SHALL abandon the frame with no FrameDone or SyncError; after release the block SHALL wait in IDLE for Arm.

Verification
REQ-033 Reset release -> State=0001, all outputs 0, ReadEnable=0 with DataReadyToSend=1.
REQ-034 Arm, FrameLength=2, bytes FF 80 7F 00 11 22 33 44 55 66 77 88, WordReady=1 -> all of:
  - WordOut 32'h11223344 then 32'h55667788.
  - WordCount=2.
  - One FrameDone pulse.
  - ReadEnable low after byte 88.
REQ-035 Bytes 00 FF FF 80 7F 00 AA BB CC DD, FrameLength=1 -> header found at the unaligned offset; single word 32'hAABBCCDD.
REQ-036 WordReady held 0 for 10 cycles after the first word -> all of:
  - ReadEnable=0 within 1 cycle.
  - WordOut stable.
  - At most one extra byte accepted.
  - The second word is correct after release.
REQ-037 TIMEOUT_CYCLES=16, only 2 payload bytes sent -> SyncError pulse 16 cycles after the last byte; State=0001; no WordValid.
REQ-038 FrameLength=0 -> FrameDone one cycle after entering DONE, no WordValid.
REQ-039 Reset mid-payload -> all outputs 0 immediately, no pulses.
